pll_phase_ctrl: RTL and testbench
=================================

Name: pll_phase_ctrl

Overview:
Controller for one ECP5 EHXPLLL instance. It runs the PLL reset and lock sequence and holds the downstream system reset until lock has been stable. It then serves dynamic phase-shift requests by driving the PLL's PHASESEL, PHASEDIR and PHASESTEP pins with the required setup and pulse timing. Loss of lock aborts any shift in progress and restarts the sequence. It sits beside the clock-generation PLL and runs from the free-running board input clock, not from any PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt
LOCK_TIMEOUT, 65535, cycles to wait for lock before retrying the reset
SETTLE_CYCLES, 1024, consecutive locked cycles required before sys_rst is released
SETUP_CYCLES, 2, cycles PHASESEL/PHASEDIR are stable before a PHASESTEP pulse
PULSE_CYCLES, 4, PHASESTEP low time and also the high gap after it, in cycles
STEP_W, 8, width of the requested step count

Ports:
clk  in  1  free-running board clock (25 MHz); the only clock
rst  in  1  synchronous, active-high reset
pll_lock  in  1  PLL LOCK output (asynchronous; 2-flop synchronised internally)
pll_rst  out  1  PLL RST
pll_phasesel  out  2  PHASESEL[1:0]: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP
pll_phasedir  out  1  PHASEDIR: 1 advance, 0 delay
pll_phasestep  out  1  PHASESTEP, idle high; each low pulse is one step
sys_rst  out  1  synchronous active-high reset for downstream logic
req_valid  in  1  phase-shift request
req_ready  out  1  request accepted when req_valid && req_ready
req_sel  in  2  output to shift
req_dir  in  1  direction
req_steps  in  STEP_W  number of steps; 0 is legal
done  out  1  one-cycle pulse when a request completes
err_lock  out  1  sticky flag: lock lost after first lock; cleared only by rst
retries  out  8  count of reset attempts after lock timeouts, saturates at 255
phase_pos  out  4*STEP_W  signed net step position per output; sel n occupies bits [n*STEP_W +: STEP_W]

Behaviour:
- Reset values:
  - pll_rst=1, sys_rst=1, pll_phasestep=1, pll_phasesel=0, pll_phasedir=0.
  - req_ready=0, done=0, err_lock=0, retries=0, phase_pos=0.
  - Synchroniser flops reset to 0. State is PRST.
- PRST: pll_rst=1 for RST_CYCLES cycles, then go to WLOCK.
- WLOCK: pll_rst=0.
  - Synced lock=1: go to SETTLE.
  - Counter reaches LOCK_TIMEOUT: retries++ (saturating), go to PRST.
- SETTLE: counts consecutive synced-lock cycles.
  - Lock drops: go to WLOCK with the timeout counter restarted.
  - Count reaches SETTLE_CYCLES: sys_rst falls on the same edge as entry to IDLE.
- IDLE: req_ready=1, the only state in which it is high.
  - On handshake, latch sel/dir/steps.
  - steps=0: done pulses the next cycle, return to IDLE, no pins move.
  - steps>0: go to SETUP.
- SETUP: drive phasesel/phasedir from the latched values, hold SETUP_CYCLES cycles, go to STEP_LO.
- STEP_LO: phasestep=0 for PULSE_CYCLES cycles, go to STEP_HI.
- STEP_HI: phasestep=1 for PULSE_CYCLES cycles.
  - On leaving, phase_pos[sel] += (dir ? +1 : -1), two's-complement wrap.
  - Decrement remaining; if nonzero go to STEP_LO, else pulse done and return to IDLE.
- phasesel/phasedir hold their last values in IDLE; they change only in SETUP.
- Duration of an N-step request, from handshake cycle to done: SETUP_CYCLES + 2*PULSE_CYCLES*N + 1 cycles.
- Lock loss while in IDLE, SETUP, STEP_LO or STEP_HI:
  - Next cycle: err_lock=1, sys_rst=1, phasestep=1, go to PRST.
  - The request in progress is dropped with no done; phase_pos is cleared to 0.
  - A partially completed step, aborted in STEP_LO, is not counted.
- rst asserted mid-operation returns every output to its reset value on the next edge.
- req_valid while not in IDLE is ignored; the requester must hold it until accepted.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum (PRST, WLOCK, SETTLE, IDLE, SETUP, STEP_LO, STEP_HI);
  - the PHASESEL encodings SEL_CLKOS=0, SEL_CLKOS2=1, SEL_CLKOS3=2, SEL_CLKOP=3.
- One sub-module: sync2, the 2-flop synchroniser for pll_lock, reset value 0.
- The FSM and counters stay in the top level.

Test Plan (bench uses RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, SETUP_CYCLES=2, PULSE_CYCLES=3):
- Power-up: lock rises 10 cycles after pll_rst falls -> sys_rst falls exactly 2+8 cycles after the lock rise; retries=0; req_ready=1.
- Lock timeout: lock held 0 -> pll_rst pulses for 4 cycles every 4+20 cycles; retries counts 1,2,3; lock then rises -> normal release.
- Shift: sel=01, dir=1, steps=3 -> phasesel=01 and phasedir=1 stable 2 cycles before the first low; three 3-cycle low pulses separated by 3-cycle highs; done at cycle 2+18+1=21 after handshake; phase_pos[1]=+3.
- Zero steps and wrap: steps=0 -> done the next cycle, phasestep never low. Then 129 delay steps on sel=00 from 0 -> phase_pos[0]=0x7F (-129 wraps).
- Lock loss in STEP_LO of step 2/5 -> no done; err_lock=1; sys_rst=1; phasestep high the next cycle; phase_pos all 0; the FSM re-enters PRST.
- Reset mid-shift: rst asserted in STEP_HI -> all outputs at reset values on the next edge; err_lock=0.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types for the ECP5 PLL phase controller: FSM states and PHASESEL codes.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PRST,
    WLOCK,
    SETTLE,
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI
  } state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

endpackage

// File: rtl/pll_phase_ctrl_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL LOCK into the board clock domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL reset/lock sequencer with dynamic phase-step control, clocked from the board clock.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned PULSE_CYCLES  = 4,
  parameter int unsigned STEP_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic [1:0]            pll_phasesel,
  output logic                  pll_phasedir,
  output logic                  pll_phasestep,
  output logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_sel,
  input  logic                  req_dir,
  input  logic [STEP_W-1:0]     req_steps,
  output logic                  done,
  output logic                  err_lock,
  output logic [7:0]            retries,
  output logic [4*STEP_W-1:0]   phase_pos
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (SETTLE_CYCLES > MAX_A) ? SETTLE_CYCLES : MAX_A;
  localparam int unsigned MAX_C   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_C > MAX_B) ? MAX_C : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pll_rst_q;
  logic                  sys_rst_q;
  logic [1:0]            phasesel_q;
  logic                  phasedir_q;
  logic                  phasestep_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  err_lock_q;
  logic [7:0]            retries_q;
  logic [4*STEP_W-1:0]   phase_pos_q;
  logic [1:0]            sel_q;
  logic                  dir_q;
  logic [STEP_W-1:0]     remain_q;
  logic                  lock_s;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      phasesel_q  <= SEL_CLKOS;
      phasedir_q  <= 1'b0;
      phasestep_q <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_lock_q  <= 1'b0;
      retries_q   <= '0;
      phase_pos_q <= '0;
      sel_q       <= SEL_CLKOS;
      dir_q       <= 1'b0;
      remain_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PRST: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_q   <= WLOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WLOCK: begin
          // The cycle that reveals lock already counts as the first settled cycle.
          if (lock_s) begin
            state_q <= SETTLE;
            cnt_q   <= CNT_W'(1);
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_q   <= PRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retries_q != 8'hFF) retries_q <= retries_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state_q <= WLOCK;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // Lock loss in any operational state drops the request and restarts the PLL.
          if (!lock_s) begin
            state_q     <= PRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            phasestep_q <= 1'b1;
            ready_q     <= 1'b0;
            err_lock_q  <= 1'b1;
            phase_pos_q <= '0;
          end else begin
            case (state_q)
              IDLE: begin
                if (req_valid) begin
                  sel_q    <= req_sel;
                  dir_q    <= req_dir;
                  remain_q <= req_steps;
                  if (req_steps == '0) begin
                    done_q <= 1'b1;
                  end else begin
                    state_q    <= SETUP;
                    cnt_q      <= '0;
                    ready_q    <= 1'b0;
                    phasesel_q <= req_sel;
                    phasedir_q <= req_dir;
                  end
                end
              end
              SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                  state_q     <= STEP_LO;
                  cnt_q       <= '0;
                  phasestep_q <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              STEP_LO: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                  state_q     <= STEP_HI;
                  cnt_q       <= '0;
                  phasestep_q <= 1'b1;
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              STEP_HI: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                  cnt_q    <= '0;
                  remain_q <= remain_q - STEP_W'(1);
                  for (int n = 0; n < 4; n++) begin
                    if (sel_q == 2'(n)) begin
                      phase_pos_q[n*STEP_W +: STEP_W] <= phase_pos_q[n*STEP_W +: STEP_W] +
                                                         (dir_q ? STEP_W'(1) : {STEP_W{1'b1}});
                    end
                  end
                  if (remain_q != STEP_W'(1)) begin
                    state_q     <= STEP_LO;
                    phasestep_q <= 1'b0;
                  end else begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                  end
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              default: begin
                state_q <= PRST;
                cnt_q   <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign pll_phasesel  = phasesel_q;
  assign pll_phasedir  = phasedir_q;
  assign pll_phasestep = phasestep_q;
  assign req_ready     = ready_q;
  assign done          = done_q;
  assign err_lock      = err_lock_q;
  assign retries       = retries_q;
  assign phase_pos     = phase_pos_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with small timing parameters and hand-computed expectations.
module tb_pll_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_lock;
  logic        pll_rst;
  logic [1:0]  pll_phasesel;
  logic        pll_phasedir;
  logic        pll_phasestep;
  logic        sys_rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_dir;
  logic [7:0]  req_steps;
  logic        done;
  logic        err_lock;
  logic [7:0]  retries;
  logic [31:0] phase_pos;

  int n_tests = 0;
  int n_fail  = 0;

  pll_phase_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8),
    .SETUP_CYCLES(2), .PULSE_CYCLES(3), .STEP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
    .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .done(done), .err_lock(err_lock),
    .retries(retries), .phase_pos(phase_pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; the caller ensures the controller is in IDLE.
  task automatic issue(input logic [1:0] s, input logic d, input logic [7:0] n);
    req_sel   = s;
    req_dir   = d;
    req_steps = n;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
    repeat (3) tick();
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
    n_tests++; if (pll_phasestep !== 1'b1) begin n_fail++; $display("FAIL reset_phasestep got %b want 1", pll_phasestep); end
    n_tests++; if ({pll_phasesel, pll_phasedir} !== 3'b000) begin n_fail++; $display("FAIL reset_sel_dir got %b want 000", {pll_phasesel, pll_phasedir}); end
    n_tests++; if ({req_ready, done, err_lock} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {req_ready, done, err_lock}); end
    n_tests++; if (retries !== 8'd0) begin n_fail++; $display("FAIL reset_retries got %0d want 0", retries); end
    n_tests++; if (phase_pos !== 32'd0) begin n_fail++; $display("FAIL reset_phase_pos got %h want 0", phase_pos); end
  endtask

  task automatic test_powerup();
    int c;
    rst = 1'b0;
    c = 0;
    while (pll_rst === 1'b1 && c < 10) begin tick(); c++; end
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL pwr_rst_len got %0d want 4", c); end
    repeat (10) tick();
    pll_lock = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (sys_rst !== (k < 10)) begin n_fail++; $display("FAIL pwr_sys_rst k=%0d got %b want %b", k, sys_rst, (k < 10)); end
    end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL pwr_ready got %b want 1", req_ready); end
    n_tests++; if (retries !== 8'd0) begin n_fail++; $display("FAIL pwr_retries got %0d want 0", retries); end
  endtask

  task automatic test_shift();
    logic exp_step;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL shift_ready_pre got %b want 1", req_ready); end
    issue(2'b01, 1'b1, 8'd3);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL shift_ready_busy got %b want 0", req_ready); end
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      exp_step = !(k >= 2 && k <= 19 && ((k - 2) % 6) < 3);
      n_tests++;
      if (pll_phasestep !== exp_step) begin n_fail++; $display("FAIL shift_step k=%0d got %b want %b", k, pll_phasestep, exp_step); end
      n_tests++;
      if (done !== (k == 20)) begin n_fail++; $display("FAIL shift_done k=%0d got %b want %b", k, done, (k == 20)); end
      n_tests++;
      if ({pll_phasesel, pll_phasedir} !== 3'b011) begin n_fail++; $display("FAIL shift_seldir k=%0d got %b want 011", k, {pll_phasesel, pll_phasedir}); end
    end
    n_tests++; if (phase_pos !== 32'h0000_0300) begin n_fail++; $display("FAIL shift_pos got %h want 00000300", phase_pos); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL shift_ready_post got %b want 1", req_ready); end
  endtask

  task automatic test_zero_wrap();
    int c;
    issue(2'b10, 1'b0, 8'd0);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_tests++; if (pll_phasestep !== 1'b1) begin n_fail++; $display("FAIL zero_step got %b want 1", pll_phasestep); end
    n_tests++; if ({pll_phasesel, pll_phasedir} !== 3'b011) begin n_fail++; $display("FAIL zero_pins_moved got %b want 011", {pll_phasesel, pll_phasedir}); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", req_ready); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b want 0", done); end
    issue(2'b00, 1'b0, 8'd129);
    c = 0;
    while (done !== 1'b1 && c < 800) begin tick(); c++; end
    n_tests++; if (c !== 776) begin n_fail++; $display("FAIL wrap_latency got %0d want 776", c); end
    n_tests++; if ({pll_phasesel, pll_phasedir} !== 3'b000) begin n_fail++; $display("FAIL wrap_seldir got %b want 000", {pll_phasesel, pll_phasedir}); end
    n_tests++; if (phase_pos !== 32'h0000_037F) begin n_fail++; $display("FAIL wrap_pos got %h want 0000037f", phase_pos); end
  endtask

  task automatic test_lock_loss();
    int  c;
    logic saw_done;
    issue(2'b11, 1'b1, 8'd5);
    repeat (7) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    n_tests++; if (pll_phasestep !== 1'b0) begin n_fail++; $display("FAIL loss_in_lo got %b want 0", pll_phasestep); end
    n_tests++; if (phase_pos !== 32'h0100_037F) begin n_fail++; $display("FAIL loss_step1_pos got %h want 0100037f", phase_pos); end
    n_tests++; if (err_lock !== 1'b0) begin n_fail++; $display("FAIL loss_err_early got %b want 0", err_lock); end
    tick();
    n_tests++; if (err_lock !== 1'b1) begin n_fail++; $display("FAIL loss_err got %b want 1", err_lock); end
    n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL loss_sys_rst got %b want 1", sys_rst); end
    n_tests++; if (pll_phasestep !== 1'b1) begin n_fail++; $display("FAIL loss_step got %b want 1", pll_phasestep); end
    n_tests++; if (phase_pos !== 32'd0) begin n_fail++; $display("FAIL loss_pos got %h want 0", phase_pos); end
    n_tests++; if ({pll_rst, req_ready, done} !== 3'b100) begin n_fail++; $display("FAIL loss_prst got %b want 100", {pll_rst, req_ready, done}); end
    c = 0; saw_done = 1'b0;
    while (pll_rst === 1'b1 && c < 10) begin tick(); c++; if (done === 1'b1) saw_done = 1'b1; end
    n_tests++; if (c !== 4) begin n_fail++; $display("FAIL loss_prst_len got %0d want 4", c); end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL loss_done got %b want 0", saw_done); end
  endtask

  task automatic test_timeout();
    int c;
    for (int r = 1; r <= 3; r++) begin
      for (int k = 1; k <= 24; k++) begin
        tick();
        n_tests++;
        if (pll_rst !== (k >= 20 && k <= 23)) begin
          n_fail++; $display("FAIL tmo_pll_rst r=%0d k=%0d got %b want %b", r, k, pll_rst, (k >= 20 && k <= 23));
        end
        if (k == 20) begin
          n_tests++;
          if (retries !== 8'(r)) begin n_fail++; $display("FAIL tmo_retries got %0d want %0d", retries, r); end
        end
      end
    end
    pll_lock = 1'b1;
    c = 0;
    while (sys_rst === 1'b1 && c < 30) begin tick(); c++; end
    n_tests++; if (c !== 10) begin n_fail++; $display("FAIL tmo_release got %0d want 10", c); end
    n_tests++; if (retries !== 8'd3) begin n_fail++; $display("FAIL tmo_retries_final got %0d want 3", retries); end
    n_tests++; if ({req_ready, err_lock} !== 2'b11) begin n_fail++; $display("FAIL tmo_ready_err got %b want 11", {req_ready, err_lock}); end
  endtask

  task automatic test_rst_mid_shift();
    issue(2'b10, 1'b0, 8'd2);
    repeat (5) tick();
    n_tests++; if ({pll_phasestep, pll_phasesel} !== 3'b110) begin n_fail++; $display("FAIL mid_pre got %b want 110", {pll_phasestep, pll_phasesel}); end
    rst = 1'b1;
    tick();
    n_tests++; if ({pll_rst, sys_rst, pll_phasestep} !== 3'b111) begin n_fail++; $display("FAIL mid_rst_hi got %b want 111", {pll_rst, sys_rst, pll_phasestep}); end
    n_tests++; if ({pll_phasesel, pll_phasedir} !== 3'b000) begin n_fail++; $display("FAIL mid_seldir got %b want 000", {pll_phasesel, pll_phasedir}); end
    n_tests++; if ({req_ready, done, err_lock} !== 3'b000) begin n_fail++; $display("FAIL mid_flags got %b want 000", {req_ready, done, err_lock}); end
    n_tests++; if (retries !== 8'd0) begin n_fail++; $display("FAIL mid_retries got %0d want 0", retries); end
    n_tests++; if (phase_pos !== 32'd0) begin n_fail++; $display("FAIL mid_pos got %h want 0", phase_pos); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_shift();
    test_zero_wrap();
    test_lock_loss();
    test_timeout();
    test_rst_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
